// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the pipeline WB stage always wins, and
// multiply/divide results queue in a small FIFO that drains into idle slots.
module wb_arbiter #(
    parameter int N          = 32,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         wb_we,
    input  logic [4:0]   wb_wa,
    input  logic [N-1:0] wb_wd,
    input  logic         md_valid,
    input  logic [4:0]   md_wa,
    input  logic [N-1:0] md_wd,
    output logic         md_ready,
    output logic         we3,
    output logic [4:0]   wa3,
    output logic [N-1:0] wd3,
    output logic [31:0]  md_pending,
    output logic         stall_req,
    output logic         err
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(STARVE_MAX + 1);
    localparam logic [CNTW-1:0] FULL = CNTW'(DEPTH);
    localparam logic [CW-1:0]   SMAX = CW'(STARVE_MAX);

    logic [4:0]      fifo_wa [DEPTH];
    logic [N-1:0]    fifo_wd [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr, slot;
    logic [CNTW-1:0] count;
    logic [CW-1:0]   starve_cnt;
    logic            pipe_live, empty, pop, push;

    assign pipe_live = wb_we && (wb_wa != 5'd0);
    assign empty     = (count == '0);
    assign pop       = !pipe_live && !empty;
    assign md_ready  = (count != FULL) || pop;
    // Writes to r0 are acknowledged but never occupy a slot.
    assign push      = md_valid && md_ready && (md_wa != 5'd0);

    always_comb begin
        we3 = 1'b0;
        wa3 = 5'd0;
        wd3 = '0;
        if (pipe_live) begin
            we3 = 1'b1;
            wa3 = wb_wa;
            wd3 = wb_wd;
        end else if (!empty) begin
            we3 = 1'b1;
            wa3 = fifo_wa[rd_ptr];
            wd3 = fifo_wd[rd_ptr];
        end
    end

    // Only slots between head and head+count hold live entries.
    always_comb begin
        md_pending = '0;
        slot       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + AW'(i);
            if (CNTW'(i) < count)
                md_pending[fifo_wa[slot]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            stall_req  <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (push) begin
                fifo_wa[wr_ptr] <= md_wa;
                fifo_wd[wr_ptr] <= md_wd;
                wr_ptr          <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: ;
            endcase

            if (empty || pop)
                starve_cnt <= '0;
            else if (starve_cnt != SMAX)
                starve_cnt <= starve_cnt + CW'(1);
            // Once raised, the bubble request holds until the head drains.
            stall_req <= (empty || pop) ? 1'b0 : (stall_req || (starve_cnt == SMAX));

            if ((pipe_live && stall_req) || (md_valid && !md_ready))
                err <= 1'b1;
        end
    end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter sitting directly upstream of the register file's single write port (we3/wa3/wd3, written on the falling clock edge).
- Merges two result sources into that one port:
  - the in-order pipeline WB stage, which cannot stall and always wins;
  - a long-latency multiply/divide unit, whose results are buffered in a small FIFO and drained into idle write slots.
- Also exports a pending-register mask to the hazard unit and a starvation stall request.

Parameters:
- N, 32, data width of register values.
- DEPTH, 4, MD result FIFO entries (power of 2, >= 2).
- STARVE_MAX, 8, cycles a non-empty FIFO head may wait before stall_req asserts.

Ports:
- clk  input  1  clock.
- reset_n  input  1  synchronous active-low reset.
- wb_we  input  1  pipeline write-back enable.
- wb_wa  input  5  pipeline destination register.
- wb_wd  input  N  pipeline write data.
- md_valid  input  1  MD unit result valid.
- md_wa  input  5  MD destination register.
- md_wd  input  N  MD result data.
- md_ready  output  1  FIFO can accept an MD result this cycle.
- we3  output  1  register-file write enable.
- wa3  output  5  register-file write address.
- wd3  output  N  register-file write data.
- md_pending  output  32  bit r set while any buffered entry targets register r.
- stall_req  output  1  request a WB bubble next cycle.
- err  output  1  sticky protocol error.

Behaviour:
- Clock is clk; reset is synchronous, active-low, named reset_n. All state changes occur on the rising edge of clk only.
- Reset values (reset_n=0 at a rising edge):
  - FIFO emptied; count=0; md_ready=1; md_pending=0.
  - starve counter=0; stall_req=0; err=0.
  - we3/wa3/wd3 follow the combinational rule below with an empty FIFO.
- Pipeline slot: pipe_live = wb_we && (wb_wa != 0).
- Port select, combinational, zero latency:
  - If pipe_live: we3=1, wa3=wb_wa, wd3=wb_wd.
  - Else if FIFO non-empty: we3=1, wa3=head.wa, wd3=head.wd, and head is popped at the rising edge.
  - Else: we3=0, wa3=0, wd3=0.
- Enqueue:
  - md_ready = (count < DEPTH) || pop_this_cycle. Full-with-simultaneous-pop accepts.
  - A transfer happens when md_valid && md_ready.
  - Transfer with md_wa=0: accepted, not stored.
  - Transfer with md_wa!=0: stored at tail.
- Simultaneous push and pop: count unchanged; pointers advance mod DEPTH (wrap-around).
- Order and data:
  - FIFO drains strictly in arrival order.
  - Stored data is never modified.
  - A pipeline write to the same register as a buffered entry does not squash the entry. The hazard unit must use md_pending to prevent this.
- md_pending: bitwise OR of the one-hot decode of wa over all valid entries. Combinational from FIFO state; it updates the cycle after push or pop.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and no pop occurs; saturates at STARVE_MAX.
  - Cleared on any pop or when the FIFO is empty.
  - stall_req is registered: it is 1 in the cycle after the counter reaches STARVE_MAX, and stays 1 until a pop occurs.
  - Upstream must present pipe_live=0 while stall_req=1.
- Protocol errors set err (sticky until reset):
  - pipe_live=1 while stall_req=1. The pipeline still wins.
  - md_valid=1 while md_ready=0. The MD result is dropped.
- Reset mid-operation: buffered entries are discarded. The MD unit is reset by the same reset_n.

Test Plan:
- Idle pass-through: wb_we=1, wb_wa=5, wb_wd=0x1234, FIFO empty -> same cycle we3=1, wa3=5, wd3=0x1234; md_pending=0.
- Drain into bubble: push MD (wa=9, wd=0xABCD) while pipe_live=1 for 3 cycles -> md_pending[9]=1 throughout; first cycle with wb_we=0 gives we3=1, wa3=9, wd3=0xABCD; md_pending=0 on the next cycle.
- Fill/wrap: keep pipe_live=1 and push 4 entries (wa=1..4) -> md_ready=0; a 5th push attempt with md_valid=1 sets err. Then 6 idle cycles with pushes of wa=6,7 interleaved -> writes appear in order 1,2,3,4,6,7; pointer wrap verified.
- Full with simultaneous pop: FIFO full, wb_we=0, md_valid=1 (wa=12) -> push accepted, head written, count stays 4.
- Starvation: one entry buffered, pipe_live=1 continuously -> stall_req rises 1 cycle after 8 waiting cycles. Pipeline then idles -> entry written and stall_req=0 the next cycle. Pipeline instead writes during stall_req -> err=1.
- Reset mid-drain and wa=0: push wa=0 -> md_pending unchanged, no write. 3 entries buffered, reset_n=0 for 1 cycle -> count=0, md_pending=0, stall_req=0, err=0; no stale writes afterward.
